// File: rtl/fetch_pkg.sv
// Shared constants and the buffered-instruction entry type for the fetch unit.
package fetch_pkg;

    localparam int          XLEN        = 32;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          INSTR_BYTES = 4;
    localparam int          FIFO_DEPTH  = 2;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: redirect input, instruction-memory request/response and decode handshake.
interface fetch_if #(
    parameter int XLEN = fetch_pkg::XLEN
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output id_valid, id_instr, id_pc,
        input  id_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  id_valid, id_instr, id_pc,
        output id_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small flushable FIFO holding fetched {instr, pc} entries; a push into a full FIFO
// is accepted when a pop frees the head slot in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int               WIDTH      = $bits(fetch_entry_t),
    parameter int               DEPTH      = FIFO_DEPTH,
    parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             full, do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
            count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Slots reset to RESET_WORD so the head reads a defined entry straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= RESET_WORD;
        end else if (do_push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential PCs to instruction memory, buffers in-order
// responses for decode, and discards responses made stale by a redirect.
module fetch_unit #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_pkg::RESET_PC)
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    import fetch_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0]   pc_reg, pc_next;
    logic [1:0]        outstanding_reg, outstanding_next;
    logic [1:0]        drop_reg, drop_next;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [2*XLEN-1:0] fifo_head;
    logic              grant, rsp, push, pop;
    logic [XLEN-1:0]   rsp_pc;

    assign bus.imem_req  = !rst && !bus.redirect_valid &&
                           (({1'b0, outstanding_reg} + 3'(fifo_count)) < 3'(FIFO_DEPTH));
    assign bus.imem_addr = pc_reg;

    assign grant = bus.imem_req && bus.imem_gnt;
    assign rsp   = bus.imem_rvalid && (outstanding_reg != 2'd0);

    // Live requests are consecutive and end just below pc, so with nothing left to
    // drop the oldest one sits outstanding instructions back from pc.
    assign rsp_pc = pc_reg - XLEN'(outstanding_reg) * XLEN'(INSTR_BYTES);
    assign push   = rsp && (drop_reg == 2'd0) && !bus.redirect_valid;

    assign bus.id_valid = !fifo_empty && !bus.redirect_valid;
    assign pop          = bus.id_valid && bus.id_ready;
    assign bus.id_instr = fifo_head[2*XLEN-1:XLEN];
    assign bus.id_pc    = fifo_head[XLEN-1:0];

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg;
        drop_next        = drop_reg;
        if (bus.redirect_valid) begin
            // Every request still in flight now belongs to the abandoned path.
            pc_next          = {bus.redirect_pc[XLEN-1:2], 2'b00};
            outstanding_next = outstanding_reg - 2'(rsp);
            drop_next        = outstanding_reg - 2'(rsp);
        end else begin
            if (grant) pc_next = pc_reg + XLEN'(INSTR_BYTES);
            outstanding_next = outstanding_reg + 2'(grant) - 2'(rsp);
            if (rsp && drop_reg != 2'd0) drop_next = drop_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= 2'd0;
            drop_reg        <= 2'd0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    fetch_fifo #(
        .WIDTH      (2 * XLEN),
        .DEPTH      (FIFO_DEPTH),
        .RESET_WORD ({{XLEN{1'b0}}, RESET_PC})
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data ({bus.imem_rdata, rsp_pc}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // A response with nothing outstanding is a memory-side protocol violation.
    rsp_without_request: assert property (
        @(posedge clk) disable iff (rst) bus.imem_rvalid |-> (outstanding_reg != 2'd0));

endmodule
